// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state enumeration and the default operand width.
package serial_sub_pkg;

  localparam int SUB_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor used as the serial datapath core.
// Ports: a, b, bin in; d = a^b^bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH edges, LSB first.
// Ports: clk, rst_n (async low), start, a, b, bin in; busy, done, diff,
// bout out; ovf out only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             br_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic             last;
  logic             fs_d;
  logic             fs_bout;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are kept aside since a_q/b_q are shifted away.
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
`endif

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Result bits enter from the MSB end so the LSB lands at bit 0
  // after WIDTH shifts.
  assign diff_d = {fs_d, diff_q[WIDTH-1:1]};
  assign cnt_d  = cnt_q + CW'(1);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= fs_bout;
          diff_q <= diff_d;
          cnt_q  <= cnt_d;
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bout_q  <= fs_bout;
`ifdef SERIAL_SUB_OVF_EN
            // fs_d is the final MSB of diff on this edge.
            ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ fs_d);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Scoreboard queue of expected results, compared on each done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic         c);
    logic [W:0] r;
    exp_t       e;
    r    = {1'b0, x} - {1'b0, y} - (W+1)'(c);
    e.d  = r[W-1:0];
    e.bo = r[W];
    e.ov = (x[W-1] ^ y[W-1]) & (x[W-1] ^ r[W-1]);
    return e;
  endfunction

  // Drive one request; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input exp_t e);
    @(negedge clk);
    a = x; b = y; bin = c; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int n, output bit to);
    n  = 0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    total++;
    if ({busy, done, diff, bout} !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%h want=0", {busy, done, diff, bout});
    end
`ifdef SERIAL_SUB_OVF_EN
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b want=0", ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [W-1:0] ta[4] = '{8'h05, 8'h03, 8'h00, 8'h80};
    logic [W-1:0] tb[4] = '{8'h03, 8'h05, 8'h00, 8'h01};
    logic         tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] td[4] = '{8'h02, 8'hFE, 8'hFF, 8'h7F};
    logic         tbo[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic         tov[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int  n;
    bit  to;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.d = td[i]; e.bo = tbo[i]; e.ov = tov[i];
      launch(ta[i], tb[i], tc[i], e);
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL vec%0d_busy got=%b want=1", i, busy);
      end
      wait_done(n, to);
      total++;
      if (to || n + 1 != 9) begin
        bad++;
        $display("FAIL vec%0d_latency got=%0d want=9", i, n + 1);
      end
      e = sb.pop_front();
      total++;
      if (diff !== e.d || bout !== e.bo) begin
        bad++;
        $display("FAIL vec%0d_result got=%h/%b want=%h/%b",
                 i, diff, bout, e.d, e.bo);
      end
`ifdef SERIAL_SUB_OVF_EN
      total++;
      if (ovf !== e.ov) begin
        bad++;
        $display("FAIL vec%0d_ovf got=%b want=%b", i, ovf, e.ov);
      end
`endif
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== e.d
          || bout !== e.bo) begin
        bad++;
        $display("FAIL vec%0d_hold got=%b%b/%h/%b want=00/%h/%b",
                 i, done, busy, diff, bout, e.d, e.bo);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    logic c;
    int   n;
    bit   to;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      launch(x, y, c, model(x, y, c));
      wait_done(n, to);
      e = sb.pop_front();
      total++;
      if (to || n != 8 || diff !== e.d || bout !== e.bo) begin
        bad++;
        $display("FAIL rand%0d %h-%h-%b got=%h/%b n=%0d want=%h/%b",
                 i, x, y, c, diff, bout, n, e.d, e.bo);
      end
    end
  endtask

  task automatic test_ignore_start;
    int   n;
    bit   to;
    exp_t e;
    launch(8'h5A, 8'h33, 1'b0, model(8'h5A, 8'h33, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    a = 8'h11; b = 8'hEE; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, to);
    total++;
    if (to || n + 4 != 9) begin
      bad++;
      $display("FAIL ignore_latency got=%0d want=9", n + 4);
    end
    e = sb.pop_front();
    total++;
    if (diff !== e.d || bout !== e.bo) begin
      bad++;
      $display("FAIL ignore_result got=%h/%b want=%h/%b",
               diff, bout, e.d, e.bo);
    end
  endtask

  task automatic test_back_to_back;
    int   n;
    bit   to;
    exp_t e;
    launch(8'h10, 8'h20, 1'b1, model(8'h10, 8'h20, 1'b1));
    wait_done(n, to);
    e = sb.pop_front();
    total++;
    if (to || diff !== e.d || bout !== e.bo) begin
      bad++;
      $display("FAIL b2b_first got=%h/%b want=%h/%b",
               diff, bout, e.d, e.bo);
    end
    a = 8'hC8; b = 8'h37; bin = 1'b0; start = 1'b1;
    sb.push_back(model(8'hC8, 8'h37, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got=busy%b done%b want=busy1 done0",
               busy, done);
    end
    wait_done(n, to);
    e = sb.pop_front();
    total++;
    if (to || n != 8 || diff !== e.d || bout !== e.bo) begin
      bad++;
      $display("FAIL b2b_second got=%h/%b n=%0d want=%h/%b n=8",
               diff, bout, n, e.d, e.bo);
    end
  endtask

  task automatic test_reset_mid;
    int   n;
    bit   to;
    int   pulses;
    exp_t e;
    launch(8'hA5, 8'h0F, 1'b0, model(8'hA5, 8'h0F, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    total++;
    if ({busy, done, diff, bout} !== '0) begin
      bad++;
      $display("FAIL midrst_outs got=%h want=0", {busy, done, diff, bout});
    end
`ifdef SERIAL_SUB_OVF_EN
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ovf got=%b want=0", ovf);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    total++;
    if (pulses != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_nodone got=%0d pulses busy%b want=0 busy0",
               pulses, busy);
    end
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    a = 8'h3C; b = 8'h4D; bin = 1'b1; start = 1'b1;
    rst_n = 1'b1;
    sb.push_back(model(8'h3C, 8'h4D, 1'b1));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, to);
    e = sb.pop_front();
    total++;
    if (to || n != 8 || diff !== e.d || bout !== e.bo) begin
      bad++;
      $display("FAIL midrst_fresh got=%h/%b n=%0d want=%h/%b n=8",
               diff, bout, n, e.d, e.bo);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_empty got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a subtraction; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend; captured on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend; captured on the accepting edge.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in; captured on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port diff, output, WIDTH bits: a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: borrow-out, 1 when a < b + bin, unsigned.
REQ-012 The block SHALL have port ovf, output, 1 bit (only with SERIAL_SUB_OVF_EN): signed-overflow flag.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE, an edge with start=1 SHALL capture a, b and bin (bin into the borrow register), clear the bit counter and enter SHIFT.
REQ-015 Each SHIFT edge SHALL process one bit, LSB first: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br); d is shifted into diff from the MSB end; the operands shift right.
REQ-016 SHIFT SHALL last exactly WIDTH edges; the edge that processes bit WIDTH-1 SHALL move the FSM to DONE.
REQ-017 Latency SHALL be fixed: done is high in the cycle WIDTH+1 edges after the accepting edge, for exactly one cycle.
REQ-018 The value in the borrow register at DONE SHALL drive bout.
REQ-019 diff and bout SHALL hold their values from DONE until the next accepting edge.
REQ-020 diff and bout SHALL not be required to show meaningful partial values during SHIFT.
REQ-021 start SHALL be ignored during SHIFT; the operation in progress SHALL not be disturbed.
REQ-022 start=1 in DONE SHALL be accepted back-to-back, with the next state SHIFT.
REQ-023 Without start, DONE SHALL return to IDLE on the next edge.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL not wrap within an operation.

Reset
REQ-025 On rst_n=0, the block SHALL immediately, without waiting for a clock edge, set state IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, and clear the borrow register and counter.
REQ-026 Reset mid-SHIFT SHALL abandon the operation; no done pulse SHALL follow.
REQ-027 The first edge after rst_n rises SHALL be able to accept start.

Configuration
REQ-028 Macro SERIAL_SUB_OVF_EN SHALL control the signed-overflow feature.
REQ-029 When SERIAL_SUB_OVF_EN is defined, the ovf port SHALL exist and SHALL be registered at DONE as (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), using the captured a and b; ovf SHALL be held like diff.
REQ-030 When SERIAL_SUB_OVF_EN is undefined, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package serial_sub_pkg SHALL hold the state enumeration (IDLE, SHIFT, DONE) and the default-width constant.
REQ-032 The one-bit full_subtractor (inputs a, b, bin; outputs d, bout) SHALL be a separate sub-module instantiated once as the datapath core.

Verification
REQ-033 The bench SHALL cover, with WIDTH=8: a=0x05, b=0x03, bin=0, start -> done after 9 edges, diff=0x02, bout=0, ovf=0.
REQ-034 The bench SHALL cover: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0.
REQ-035 The bench SHALL cover: a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; and a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1 (macro defined).
REQ-036 The bench SHALL cover: start pulsed with new operands at the 3rd SHIFT cycle -> ignored, first result unchanged; start held during DONE -> second result after a further 8 edges.
REQ-037 The bench SHALL cover: rst_n low at the 4th SHIFT cycle -> outputs 0 immediately, no done pulse; a fresh start then gives the correct result.
